// File: rtl/switch_debounce_4.sv
// -----------------------------------------------------------------------------
// switch_debounce_4
//
// Four-channel push-switch debouncer. Each raw, asynchronous, bouncy switch
// input passes through a 2-flop synchroniser and then a stability counter.
// A change is only accepted once the synchronised input has differed from
// the current stable level for DEBOUNCE_LIMIT consecutive cycles. Any return
// to the stable level throws the partial count away.
// A debounced 0->1 transition also raises a registered one-cycle press pulse.
//
// Parameters
//   DEBOUNCE_LIMIT  cycles a change must persist before it is accepted (>= 2)
//
// Ports
//   i_Clk        in   1  system clock, all logic on the rising edge
//   i_Rst_L      in   1  synchronous reset, active-low
//   i_Switch_1   in   1  raw switch 1 (asynchronous, bouncy)
//   i_Switch_2   in   1  raw switch 2
//   i_Switch_3   in   1  raw switch 3
//   i_Switch_4   in   1  raw switch 4
//   o_Switch_1   out  1  debounced level, switch 1
//   o_Switch_2   out  1  debounced level, switch 2
//   o_Switch_3   out  1  debounced level, switch 3
//   o_Switch_4   out  1  debounced level, switch 4
//   o_Press      out  4  bit n-1 pulses for one cycle when o_Switch_n goes 0->1
// -----------------------------------------------------------------------------
module switch_debounce_4 #(
    parameter int DEBOUNCE_LIMIT = 250000
) (
    input  logic       i_Clk,
    input  logic       i_Rst_L,
    input  logic       i_Switch_1,
    input  logic       i_Switch_2,
    input  logic       i_Switch_3,
    input  logic       i_Switch_4,
    output logic       o_Switch_1,
    output logic       o_Switch_2,
    output logic       o_Switch_3,
    output logic       o_Switch_4,
    output logic [3:0] o_Press
);

    // Counter width follows from the limit; the count tops out at
    // DEBOUNCE_LIMIT-1, which always fits in $clog2(DEBOUNCE_LIMIT) bits.
    localparam int CNT_W = $clog2(DEBOUNCE_LIMIT);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_LIMIT - 1);

    logic [3:0] raw;
    logic [3:0] level;
    logic [3:0] press;

    assign raw = {i_Switch_4, i_Switch_3, i_Switch_2, i_Switch_1};

    generate
        for (genvar n = 0; n < 4; n++) begin : g_chan
            logic             sync1;
            logic             sync2;
            logic             stable;
            logic             pulse;
            logic [CNT_W-1:0] cnt;
            logic             differs;
            logic             commit;

            // The change is committed on the edge where the count has already
            // reached its ceiling and the input still disagrees.
            always_comb begin
                differs = (sync2 != stable);
                commit  = differs && (cnt == CNT_MAX);
            end

            // Synchroniser, stability counter, stable level and press pulse.
            // The pulse is registered on the same edge that commits a 1, so it
            // is high exactly in the first cycle the new level is visible.
            always_ff @(posedge i_Clk) begin
                if (!i_Rst_L) begin
                    sync1  <= 1'b0;
                    sync2  <= 1'b0;
                    stable <= 1'b0;
                    pulse  <= 1'b0;
                    cnt    <= '0;
                end else begin
                    sync1 <= raw[n];
                    sync2 <= sync1;
                    pulse <= commit && sync2;
                    if (!differs) begin
                        cnt <= '0;
                    end else if (commit) begin
                        stable <= sync2;
                        cnt    <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
            end

            assign level[n] = stable;
            assign press[n] = pulse;
        end
    endgenerate

    assign o_Switch_1 = level[0];
    assign o_Switch_2 = level[1];
    assign o_Switch_3 = level[2];
    assign o_Switch_4 = level[3];
    assign o_Press    = press;

endmodule
